// File: rtl/spi_flash_reader_pkg.sv
// ---------------------------------------------------------------------------
// spi_flash_reader_pkg
//   Shared types and constants for the SPI flash reader.
//   - state_t   : controller FSM states
//   - CMD_READ  : serial flash READ opcode (03h, no dummy cycles)
//   - ADDR_W    : flash byte-address width
//   - HDR_BITS  : opcode plus address bits shifted out before data
// ---------------------------------------------------------------------------
package spi_flash_reader_pkg;

  localparam int          ADDR_W   = 24;
  localparam logic [7:0]  CMD_READ = 8'h03;
  localparam int          HDR_BITS = 8 + ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    STALL,
    CSHI
  } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// ---------------------------------------------------------------------------
// spi_clk_div
//   Half-period tick generator for the SPI clock. While enabled, tick pulses
//   for one cycle every CLK_DIV cycles. clr restarts the count so that the
//   next tick comes a full CLK_DIV cycles later.
//   Ports:
//     clk  : system clock
//     rst  : synchronous active-high reset
//     en   : count enable; the counter is held at zero while low
//     clr  : restart the half-period count
//     tick : one-cycle pulse at the end of each half period
// ---------------------------------------------------------------------------
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [7:0] cnt_q;

  assign tick = en && (cnt_q == 8'(CLK_DIV - 1));

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst || clr || !en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// ---------------------------------------------------------------------------
// spi_flash_reader
//   Reads a run of bytes from a SPI NOR flash with the READ (03h) command in
//   SPI mode 0 and streams them out over a valid/ready byte interface. When
//   the consumer holds off, the SPI clock is parked low between bytes so the
//   flash keeps its place and nothing is dropped.
//   Ports:
//     wb_clk_i      : system clock, everything on the rising edge
//     wb_rst_i      : synchronous active-high reset (aborts a transfer)
//     start_i       : start request, accepted only when idle
//     addr_i/len_i  : flash byte address and byte count, captured on start
//     busy_o        : transaction in progress
//     done_o        : one-cycle end-of-transaction pulse
//     data_o        : received byte, qualified by data_valid_o
//     data_ready_i  : consumer accepts data_o when data_valid_o is high
//     flash_csb_o   : chip select, active low
//     flash_clk_o   : SPI clock, idles low
//     flash_io0_o   : MOSI
//     flash_io1_i   : MISO
// ---------------------------------------------------------------------------
module spi_flash_reader
  import spi_flash_reader_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        data_o,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic              flash_csb_o,
  output logic              flash_clk_o,
  output logic              flash_io0_o,
  input  logic              flash_io1_i
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t state_q, state_d;

  logic                tick;
  logic                div_en, div_clr;
  logic                accept, xfer, shifting;
  logic                sck_rise, sck_fall;
  logic                load_byte, done_d;

  logic                sck_q, csb_q, done_q, valid_q, cshi_half_q;
  logic [7:0]          data_q;
  logic [HDR_BITS-1:0] tx_sr_q;
  logic [7:0]          rx_sr_q;
  logic [4:0]          bit_cnt_q;
  logic [LEN_W-1:0]    rem_q;

  assign accept   = start_i && (state_q == IDLE);
  assign xfer     = valid_q && data_ready_i;
  assign shifting = state_q inside {CMD, ADDR, DATA};
  assign sck_rise = shifting && tick && !sck_q;
  assign sck_fall = shifting && tick &&  sck_q;

  // The divider runs while bits are moving and during the CS-high hold; it
  // restarts on every state change so each phase begins on a full half period.
  assign div_en  = shifting || (state_q == CSHI);
  assign div_clr = (state_d != state_q);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .en   (div_en),
    .clr  (div_clr),
    .tick (tick)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bits move on the falling SCK edge and are sampled on the rising one, so
  // a field boundary is recognised when the last bit's high phase ends.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    state_d   = state_q;
    load_byte = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (len_i != '0) state_d = CMD;
          else             done_d  = 1'b1;
        end
      end
      CMD: begin
        if (sck_fall && bit_cnt_q == 5'd7) state_d = ADDR;
      end
      ADDR: begin
        if (sck_fall && bit_cnt_q == 5'(HDR_BITS - 1)) state_d = DATA;
      end
      DATA: begin
        if (sck_fall && bit_cnt_q == 5'd7) begin
          // Output register still full and not draining: park the byte in
          // the shift register and stop the clock until there is room.
          if (valid_q && !xfer) begin
            state_d = STALL;
          end else begin
            load_byte = 1'b1;
            if (rem_q == LEN_ONE) state_d = CSHI;
          end
        end
      end
      STALL: begin
        if (xfer) begin
          load_byte = 1'b1;
          state_d   = (rem_q == LEN_ONE) ? CSHI : DATA;
        end
      end
      CSHI: begin
        if (tick && cshi_half_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sck_q       <= 1'b0;
      csb_q       <= 1'b1;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      cshi_half_q <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      rem_q       <= '0;
    end else begin
      // Chip select follows the next state so it changes together with it.
      csb_q  <= !(state_d inside {CMD, ADDR, DATA, STALL});
      done_q <= done_d;

      if (!shifting) sck_q <= 1'b0;
      else if (tick) sck_q <= !sck_q;

      cshi_half_q <= (state_q == CSHI) ? (cshi_half_q ^ tick) : 1'b0;

      if (accept && len_i != '0) begin
        tx_sr_q   <= {CMD_READ, addr_i};
        rem_q     <= len_i;
        bit_cnt_q <= '0;
      end else begin
        // Zeros shift in behind the header, which keeps MOSI low during DATA.
        if (sck_fall) begin
          tx_sr_q <= {tx_sr_q[HDR_BITS-2:0], 1'b0};
          if ((state_q == ADDR && bit_cnt_q == 5'(HDR_BITS - 1)) ||
              (state_q == DATA && bit_cnt_q == 5'd7)) begin
            bit_cnt_q <= '0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
          end
        end
        if (load_byte) rem_q <= rem_q - LEN_ONE;
      end

      if (sck_rise && state_q == DATA) rx_sr_q <= {rx_sr_q[6:0], flash_io1_i};

      if (load_byte) begin
        data_q  <= rx_sr_q;
        valid_q <= 1'b1;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign flash_csb_o  = csb_q;
  assign flash_clk_o  = sck_q;
  assign flash_io0_o  = tx_sr_q[HDR_BITS-1];

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 Parameter CLK_DIV, default 2: SPI clock half-period in wb_clk_i cycles; legal range 1..255.
REQ-002 Parameter LEN_W, default 16: width of the byte-count input.
REQ-003 Port wb_clk_i  in  1: the only clock; all logic is sampled on its rising edge.
REQ-004 Port wb_rst_i  in  1: reset, synchronous and active-high.
REQ-005 Port start_i  in  1: single-cycle request to start a read; honoured only while busy_o=0.
REQ-006 Port addr_i  in  24: flash byte address, captured on an accepted start_i.
REQ-007 Port len_i  in  LEN_W: number of bytes to read, captured on an accepted start_i.
REQ-008 Port busy_o  out  1: high from the cycle after an accepted start until done_o.
REQ-009 Port done_o  out  1: one-cycle pulse marking the end of a transaction.
REQ-010 Port data_o  out  8: byte read from flash.
REQ-011 Port data_valid_o  out  1: data_o holds a valid byte.
REQ-012 Port data_ready_i  in  1: consumer accepts the byte; transfer occurs when data_valid_o=1 and data_ready_i=1.
REQ-013 Port flash_csb_o  out  1: flash chip select, active-low.
REQ-014 Port flash_clk_o  out  1: SPI clock in mode 0 (idles low).
REQ-015 Port flash_io0_o  out  1: MOSI.
REQ-016 Port flash_io1_i  in  1: MISO.

Function
REQ-017 The FSM states shall be IDLE, CMD, ADDR, DATA, STALL, CSHI.
REQ-018 In IDLE with start_i=1 and len_i!=0: capture addr_i and len_i, drive flash_csb_o=0, and go to CMD on the next cycle.
REQ-019 In IDLE with start_i=1 and len_i=0: no SPI activity; done_o pulses on the next cycle and busy_o stays 0.
REQ-020 Each SPI bit takes 2*CLK_DIV cycles: flash_clk_o low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-021 flash_io0_o shall change only while flash_clk_o is low; flash_io1_i shall be sampled on the rising edge of flash_clk_o; all fields are MSB first.
REQ-022 CMD shifts out 8'h03 (8 bits), then ADDR shifts out the 24-bit address, then DATA begins; flash_io0_o=0 during DATA.
REQ-023 After 8 sampled data bits the byte loads into data_o with data_valid_o=1, and the remaining count decrements.
REQ-024 data_valid_o clears on the cycle after a transfer unless a new byte loads in that same cycle.
REQ-025 If a byte completes while data_valid_o=1 and no transfer occurs that cycle, the FSM enters STALL: flash_clk_o held low, flash_csb_o held low, shift register kept intact.
REQ-026 STALL returns to DATA on the cycle after the pending byte transfers; no flash data is lost or duplicated.
REQ-027 When the last byte is loaded, go to CSHI: flash_csb_o=1 and flash_clk_o=0 for 2*CLK_DIV cycles, then done_o pulses and the FSM returns to IDLE.
REQ-028 done_o does not wait for the last byte to be consumed; data_valid_o may remain high after done_o.
REQ-029 start_i while busy_o=1 is ignored with no side effects.
REQ-030 The byte count wraps nowhere: len_i = 2**LEN_W-1 bytes are delivered; the flash address auto-increments in the device, and the block never re-sends an address.

Reset
REQ-031 With wb_rst_i=1 at a clock edge, the next-cycle outputs shall be: flash_csb_o=1, flash_clk_o=0, flash_io0_o=0, busy_o=0, done_o=0, data_valid_o=0, data_o=8'h00; state=IDLE.
REQ-032 Reset asserted mid-transaction aborts it immediately (no CSHI wait, no done_o pulse) and drops any pending byte.

Structure
REQ-033 Package spi_flash_reader_pkg shall hold the state enum, CMD_READ=8'h03 and ADDR_W=24.
REQ-034 Sub-module spi_clk_div shall generate the CLK_DIV tick with enable/clear controls; all other logic stays in spi_flash_reader.

Verification
REQ-035 Memory model preloaded bytes 00..0F = 8'h10..8'h1F; CLK_DIV=2; start with addr=24'h000004, len=4, data_ready_i=1 -> MOSI bits 03 000004, bytes 14 15 16 17, exactly one done_o pulse, CSB high for at least 4 cycles afterwards.
REQ-036 Same transaction with data_ready_i=0 until the 2nd byte completes -> STALL entered with SCK held low for the whole stall; after release, bytes 14 15 16 17 delivered in order with no gaps or duplicates.
REQ-037 len=0 -> CSB stays 1, no SCK edges, done_o pulses 1 cycle after start, busy_o stays 0.
REQ-038 Assert reset during the ADDR phase (bit 10) -> CSB=1 next cycle, no done_o pulse, data_valid_o=0; a following start with addr=0, len=1 returns 8'h10.
REQ-039 start_i pulsed again mid-DATA with different addr/len -> ignored; the original transaction completes unchanged.
REQ-040 CLK_DIV=1 and CLK_DIV=5 -> SCK period is 2 and 10 cycles respectively, with the same byte results.
